snooper_capture_ctrl: RTL
=========================

# snooper_capture_ctrl

Sequencing controller for the snooper capture path. It arms on software command and waits for an optional start-PC trigger. It then captures traces that pass the privilege/PC-range filter into a small FIFO toward the trace sink, and stops on a sample limit, a stop-PC trigger or an abort. It sits between the core trace port plus the filter's `enable_o`, and the downstream trace writer, and raises a completion interrupt.

## Interface
- `FifoDepth`, 4: capture FIFO entries; power of two, ≥2.
- `CntWidth`, 32: width of the sample and drop counters and of the limit.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. The clock is `clk_i`; reset `rst_ni` is asynchronous, active-low.
- `arm_i` in 1: one-cycle pulse; starts a capture session.
- `abort_i` in 1: one-cycle pulse; kills the session.
- `start_en_i` in 1: enables the start-PC trigger.
- `start_pc_i` in 64: start-trigger PC.
- `stop_en_i` in 1: enables the stop-PC trigger.
- `stop_pc_i` in 64: stop-trigger PC.
- `limit_i` in CntWidth: number of samples to capture; 0 means unlimited.
- `trace_valid_i` in 1: a trace is present this cycle. There is no backpressure on this input.
- `trace_i` in `trace_t`: trace; PC = {`pc_src_h`, `pc_src_l`}.
- `filter_en_i` in 1: filter verdict for `trace_i`.
- `trace_valid_o` out 1: FIFO head valid.
- `trace_o` out `trace_t`: FIFO head.
- `trace_ready_i` in 1: the sink accepts the head.
- `state_o` out 3: current state.
- `busy_o` out 1: state is ARMED, ACTIVE or DRAIN.
- `done_o` out 1: state is DONE.
- `irq_o` out 1: one-cycle completion pulse.
- `sample_cnt_o` out CntWidth: traces pushed in this session.
- `drop_cnt_o` out CntWidth: filtered traces lost because the FIFO was full.

## Operation
- States: IDLE=0, ARMED=1, ACTIVE=2, DRAIN=3, DONE=4.
- **IDLE / DONE**
  - `arm_i`: clear `sample_cnt`, `drop_cnt` and the FIFO.
  - Go to ARMED if `start_en_i`, else go to ACTIVE.
  - Traces are ignored in IDLE and DONE.
- **ARMED**
  - On `trace_valid_i` with PC == `start_pc_i`, go to ACTIVE.
  - The trigger trace itself is captured in the same cycle if `filter_en_i` is set.
- **ACTIVE**
  - A *qualified* trace has `trace_valid_i & filter_en_i`.
  - Qualified, FIFO has room: push the trace and increment `sample_cnt`.
  - Qualified, FIFO full: drop the trace and increment `drop_cnt`.
- **Room**: the FIFO has room when count < FifoDepth, or when a pop happens in the same cycle.
- **Stop conditions**, evaluated on the same trace, all lead to DRAIN:
  - a push brings `sample_cnt` to `limit_i` (with `limit_i` ≠ 0);
  - `stop_en_i` and PC == `stop_pc_i`; this trace is still pushed or dropped as above.
- **Start and stop on one trace**: if start and stop match on the same trace while ARMED, that trace is handled as ACTIVE and the FSM goes directly to DRAIN.
- **DRAIN**: no pushes. When the FIFO is empty, or becomes empty by a pop this cycle, go to DONE and pulse `irq_o`.
- **`abort_i`** in any state:
  - go to IDLE next cycle and flush the FIFO;
  - no `irq_o`;
  - counters are held.
- **`abort_i` with `arm_i`** in the same cycle: abort wins.
- **`arm_i` while busy**: ignored.
- **Counters**: both are unsigned and saturate at all-ones.
- **Limit**: `limit_i` is sampled at arm and held for the session, so later changes have no effect until the next arm.
- **PCs**: `start_pc_i` and `stop_pc_i` are compared live.

## Timing
- Reset values:
  - state IDLE;
  - FIFO empty;
  - `trace_valid_o`=0, `trace_o`='0;
  - `irq_o`=0, `done_o`=0, `busy_o`=0;
  - both counters 0.
- Latency:
  - an accepted trace appears on `trace_o` no earlier than the next cycle (registered FIFO, no fall-through);
  - a full FIFO sustains 1 pop and 1 push per cycle.
- Handshake:
  - `trace_o` and `trace_valid_o` are stable while `trace_valid_o & !trace_ready_i`;
  - a pop happens on `trace_valid_o & trace_ready_i`.
- `state_o`, `busy_o` and `done_o` reflect the registered state.
- `irq_o` is high for exactly the first cycle of DONE.
- An asynchronous reset in mid-session returns the block to IDLE immediately; FIFO contents are discarded.

## Configuration
- `SNOOPER_DROP_CNT_EN`:
  - Defined: `drop_cnt` is implemented as specified.
  - Undefined: `drop_cnt_o` is tied to 0 and no drop-counter flops exist. Drop behaviour (trace discarded when the FIFO is full) is unchanged.

## Structure
- `snooper_pkg` holds:
  - `capture_state_e` (3-bit enum with the encodings above);
  - `trace_t`.
- One sub-module, `snooper_trace_fifo`: a parameterised `trace_t` FIFO with push/pop/flush, full/empty and count.
- FSM, trigger compare and counters live in the top module.

## Test plan
- **Plain capture**
  - Setup: `start_en_i`=0, `limit_i`=3, sink always ready.
  - Stimulus: arm, then 5 qualified traces.
  - Required: exactly 3 traces output, in order; DRAIN, then DONE; one `irq_o` pulse; `sample_cnt_o`=3.
- **Start trigger**
  - Setup: `start_pc_i`=0x8000_0100.
  - Stimulus: traces at 0x8000_00F0, 0x8000_0100, 0x8000_0104, all filtered.
  - Required: output is 0x8000_0100 and 0x8000_0104 only.
- **Overflow**
  - Setup: `FifoDepth`=4, `trace_ready_i`=0, `limit_i`=0.
  - Stimulus: 6 qualified traces.
  - Required: `sample_cnt_o`=4, `drop_cnt_o`=2. Without `SNOOPER_DROP_CNT_EN`: `drop_cnt_o`=0.
- **Stop trigger**
  - Setup: `stop_pc_i` matches the 2nd trace; sink stalled for 5 cycles.
  - Required: the stop trace is output; no `irq_o` until the FIFO empties, then exactly one pulse.
- **Abort**
  - Stimulus: `abort_i` while ACTIVE with 2 FIFO entries.
  - Required: next cycle IDLE, `trace_valid_o`=0, no `irq_o`.
  - Stimulus: `arm_i` and `abort_i` in the same cycle.
  - Required: stays IDLE.
- **Reset mid-DRAIN**
  - Stimulus: `rst_ni` asserted in DRAIN.
  - Required: all outputs at reset values while reset is low.

Source files
------------

// File: rtl/snooper_pkg.sv
// Shared types for the snooper capture path: FSM state encoding, trace record
// and a PC extraction helper.
package snooper_pkg;

  typedef enum logic [2:0] {
    CS_IDLE   = 3'd0,
    CS_ARMED  = 3'd1,
    CS_ACTIVE = 3'd2,
    CS_DRAIN  = 3'd3,
    CS_DONE   = 3'd4
  } capture_state_e;

  typedef struct packed {
    logic [1:0]  priv;
    logic [31:0] pc_src_h;
    logic [31:0] pc_src_l;
    logic [31:0] insn;
  } trace_t;

  function automatic logic [63:0] trace_pc(input trace_t t);
    return {t.pc_src_h, t.pc_src_l};
  endfunction

endpackage

// File: rtl/snooper_trace_fifo.sv
// Registered trace_t FIFO with push/pop/flush. The head is read from storage,
// so a pushed entry is visible no earlier than the following cycle.
module snooper_trace_fifo
  import snooper_pkg::*;
#(
  parameter int Depth = 4,
  localparam int AW = $clog2(Depth)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  trace_t       data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output trace_t       data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  trace_t        mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_en, pop_en;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign valid_o = !empty_o;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  // Head forced to zero when empty so stale entries never leak after a flush.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_mem
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mem_q[gi] <= '0;
        end else if (push_en && !flush_i && (wr_ptr_q == AW'(gi))) begin
          mem_q[gi] <= data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/snooper_capture_ctrl.sv
// Capture sequencer: arm, optional start-PC trigger, filtered capture into a
// FIFO, stop on limit/stop-PC/abort, drain and completion irq.
// Define SNOOPER_DROP_CNT_EN to implement the drop counter.
module snooper_capture_ctrl
  import snooper_pkg::*;
#(
  parameter int FifoDepth = 4,
  parameter int CntWidth  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic                start_en_i,
  input  logic [63:0]         start_pc_i,
  input  logic                stop_en_i,
  input  logic [63:0]         stop_pc_i,
  input  logic [CntWidth-1:0] limit_i,
  input  logic                trace_valid_i,
  input  trace_t              trace_i,
  input  logic                filter_en_i,
  output logic                trace_valid_o,
  output trace_t              trace_o,
  input  logic                trace_ready_i,
  output logic [2:0]          state_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                irq_o,
  output logic [CntWidth-1:0] sample_cnt_o,
  output logic [CntWidth-1:0] drop_cnt_o
);

  localparam int CW = $clog2(FifoDepth) + 1;

  capture_state_e      state_q, state_d;
  logic [CntWidth-1:0] sample_cnt_q, sample_cnt_d;
  logic [CntWidth-1:0] limit_q, limit_d;
  logic [CntWidth-1:0] sample_inc;
  logic                irq_q;

  logic                fifo_push, fifo_pop, fifo_flush;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;

  logic [63:0]         pc;
  logic                room, qualified, start_hit, stop_hit, capture;
  logic                drop_ev, clr_cnt;

  assign pc         = trace_pc(trace_i);
  assign fifo_pop   = trace_valid_o & trace_ready_i;
  assign room       = !fifo_full || fifo_pop;
  assign qualified  = trace_valid_i && filter_en_i;
  assign start_hit  = trace_valid_i && (pc == start_pc_i);
  assign stop_hit   = stop_en_i && trace_valid_i && (pc == stop_pc_i);
  assign sample_inc = (sample_cnt_q == '1) ? sample_cnt_q : sample_cnt_q + CntWidth'(1);

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    limit_d      = limit_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    drop_ev      = 1'b0;
    clr_cnt      = 1'b0;
    capture      = 1'b0;

    if (abort_i) begin
      state_d    = CS_IDLE;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        CS_IDLE, CS_DONE: begin
          if (arm_i) begin
            clr_cnt      = 1'b1;
            sample_cnt_d = '0;
            limit_d      = limit_i;
            fifo_flush   = 1'b1;
            state_d      = start_en_i ? CS_ARMED : CS_ACTIVE;
          end
        end
        CS_ARMED:  capture = start_hit;
        CS_ACTIVE: capture = 1'b1;
        CS_DRAIN: begin
          if (fifo_empty || (fifo_pop && (fifo_count == CW'(1)))) begin
            state_d = CS_DONE;
          end
        end
        default: state_d = CS_IDLE;
      endcase

      // The start-trigger trace is handled exactly like an ACTIVE-state trace.
      if (capture) begin
        state_d = CS_ACTIVE;
        if (qualified) begin
          if (room) begin
            fifo_push    = 1'b1;
            sample_cnt_d = sample_inc;
            if ((limit_q != '0) && (sample_inc == limit_q)) begin
              state_d = CS_DRAIN;
            end
          end else begin
            drop_ev = 1'b1;
          end
        end
        if (stop_hit) begin
          state_d = CS_DRAIN;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CS_IDLE;
      sample_cnt_q <= '0;
      limit_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      limit_q      <= limit_d;
      irq_q        <= (state_q == CS_DRAIN) && (state_d == CS_DONE);
    end
  end

`ifdef SNOOPER_DROP_CNT_EN
  logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_cnt) begin
      drop_cnt_d = '0;
    end else if (drop_ev && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  logic drop_unused;
  assign drop_unused = drop_ev ^ clr_cnt;
  assign drop_cnt_o  = '0;
`endif

  snooper_trace_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (trace_i),
    .pop_i   (fifo_pop),
    .valid_o (trace_valid_o),
    .data_o  (trace_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign state_o      = state_q;
  assign busy_o       = (state_q == CS_ARMED) || (state_q == CS_ACTIVE) || (state_q == CS_DRAIN);
  assign done_o       = (state_q == CS_DONE);
  assign irq_o        = irq_q;
  assign sample_cnt_o = sample_cnt_q;

endmodule
